// File: rtl/sweep_ctrl.sv
// Triangular sweep sequencer for an external 8-bit up/down counter.
// Loads lo, runs N lo->hi->lo sweeps and cross-checks every counter value it sees.
module sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NW-1:0]    n_sweeps,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [NW-1:0] REM_ONE = {{(NW-1){1'b0}}, 1'b1};

    // Modulo-2^WIDTH step helpers; a legal configuration never wraps.
    function automatic logic [WIDTH-1:0] step_inc(input logic [WIDTH-1:0] x);
        return x + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] step_dec(input logic [WIDTH-1:0] x);
        return x - 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [NW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             mismatch;
    logic             cfg_bad;

    assign mismatch = (cnt_value != exp_q);
    assign cfg_bad  = (lo >= hi) || (n_sweeps == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
            exp_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        rem_d    = rem_q;
        exp_d    = exp_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_en   = 1'b0;
        cnt_up   = 1'b0;
        cnt_load = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // abort in the same cycle cancels the request outright
                if (start && !abort) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d    = lo;
                        hi_d    = hi;
                        rem_d   = n_sweeps;
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    exp_d    = lo_q;
                    state_d  = S_UP;
                end
            end

            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mismatch) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_value != hi_q) begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b1;
                    exp_d  = step_inc(exp_q);
                end else begin
                    cnt_en  = 1'b1;
                    exp_d   = step_dec(exp_q);
                    state_d = S_DOWN;
                end
            end

            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mismatch) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_value != lo_q) begin
                    cnt_en = 1'b1;
                    exp_d  = step_dec(exp_q);
                end else if (rem_q > REM_ONE) begin
                    // turn around at lo and start the next sweep
                    rem_d   = rem_q - 1'b1;
                    cnt_en  = 1'b1;
                    cnt_up  = 1'b1;
                    exp_d   = step_inc(exp_q);
                    state_d = S_UP;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cnt_load_val = lo_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: a reference counter, a queue-based expected
// trace built from sweep arithmetic, and a monitor comparing every observed output.
module tb_sweep_ctrl;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;

    localparam int M_NORM      = 0;
    localparam int M_ABORT     = 1;
    localparam int M_RESET     = 2;
    localparam int M_SKIP      = 3;
    localparam int M_STABRT    = 4;
    localparam int M_BUSYSTART = 5;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] n_sweeps;
    logic [7:0] cnt_value;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       busy;
    logic       done;
    logic       err;

    sweep_ctrl #(.WIDTH(8), .NW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .lo           (lo),
        .hi           (hi),
        .n_sweeps     (n_sweeps),
        .cnt_value    (cnt_value),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference counter: load beats enable; skip_at forces a +2 step from that value.
    logic [7:0] cnt_m   = 8'd0;
    int         skip_at = -1;
    assign cnt_value = cnt_m;

    always @(posedge clk) begin
        if (cnt_load === 1'b1)
            cnt_m <= cnt_load_val;
        else if (cnt_en === 1'b1) begin
            if (cnt_up === 1'b1 && skip_at == int'(cnt_m))
                cnt_m <= cnt_m + 8'd2;
            else if (cnt_up === 1'b1)
                cnt_m <= cnt_m + 8'd1;
            else
                cnt_m <= cnt_m - 8'd1;
        end
    end

    // Scoreboard state shared between stimulus and monitor.
    logic [7:0] val_q[$];
    logic [7:0] load_q[$];
    ev_t        ev_q[$];
    int         b_start     = 0;
    int         b_end       = 0;
    int         rst_chk_cyc = -1;
    int         fin_cyc     = -1;
    bit         mon_on      = 1'b0;

    int   checks = 0;
    int   errors = 0;
    bit   stepped = 1'b0;
    ev_t  e_m;
    logic [7:0] v_m;

    task automatic cmp(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic chk_event(input string nm, input int kind);
        if (ev_q.size() == 0) begin
            cmp({nm, "_unexpected"}, 1, 0);
        end else begin
            e_m = ev_q.pop_front();
            cmp({nm, "_kind"}, kind, e_m.kind);
            cmp({nm, "_cycle"}, cyc, e_m.at);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            cmp("busy", int'(busy === 1'b1), int'(cyc >= b_start && cyc < b_end));
            if (stepped) begin
                if (val_q.size() == 0) begin
                    cmp("counter_extra_step", int'(cnt_value), -1);
                end else begin
                    v_m = val_q.pop_front();
                    cmp("counter_value", int'(cnt_value), int'(v_m));
                end
            end
            stepped = (cnt_en === 1'b1) || (cnt_load === 1'b1);
            if (cnt_load === 1'b1) begin
                if (load_q.size() == 0) begin
                    cmp("load_unexpected", int'(cnt_load_val), -1);
                end else begin
                    v_m = load_q.pop_front();
                    cmp("load_value", int'(cnt_load_val), int'(v_m));
                end
            end
            if (done === 1'b1) chk_event("done", K_DONE);
            if (err === 1'b1) chk_event("err", K_ERR);
            if (cyc == rst_chk_cyc) begin
                cmp("rst_busy", int'(busy), 0);
                cmp("rst_done", int'(done), 0);
                cmp("rst_err", int'(err), 0);
                cmp("rst_cnt_en", int'(cnt_en), 0);
                cmp("rst_cnt_up", int'(cnt_up), 0);
                cmp("rst_cnt_load", int'(cnt_load), 0);
                cmp("rst_load_val", int'(cnt_load_val), 0);
            end
            if (cyc == fin_cyc) begin
                cmp("values_never_seen", val_q.size(), 0);
                cmp("loads_never_seen", load_q.size(), 0);
                cmp("events_never_seen", ev_q.size(), 0);
            end
        end
    end

    // First `limit` values of N triangular sweeps lo..hi..lo, endpoints shared.
    function automatic void push_vals(input int l, input int h, input int n, input int limit);
        int k = 0;
        if (k < limit) val_q.push_back(8'(l));
        k++;
        for (int s = 0; s < n; s++) begin
            for (int v = l + 1; v <= h; v++) begin
                if (k < limit) val_q.push_back(8'(v));
                k++;
            end
            for (int v = h - 1; v >= l; v--) begin
                if (k < limit) val_q.push_back(8'(v));
                k++;
            end
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; the start is sampled at the next edge (e0).
    task automatic run(input int l, input int h, input int n, input int mode, input int p);
        int e0;
        int len;
        bit legal;
        legal = (l < h) && (n != 0);
        len   = 2 * n * (h - l) + 1;
        e0    = cyc + 1;
        lo       = 8'(l);
        hi       = 8'(h);
        n_sweeps = 4'(n);

        if (mode == M_STABRT) begin
            start = 1'b1;
            abort = 1'b1;
            next_cycle();
            start = 1'b0;
            abort = 1'b0;
            repeat (2) next_cycle();
            return;
        end

        if (!legal) begin
            ev_q.push_back('{K_ERR, e0});
        end else begin
            load_q.push_back(8'(l));
            b_start = e0;
            case (mode)
                M_ABORT: begin
                    push_vals(l, h, n, p);
                    b_end = e0 + p + 1;
                end
                M_RESET: begin
                    push_vals(l, h, n, p + 1);
                    b_end = e0 + p + 1;
                end
                M_SKIP: begin
                    push_vals(l, h, n, p - l + 1);
                    val_q.push_back(8'(p + 2));
                    ev_q.push_back('{K_ERR, e0 + 3 + p - l});
                    b_end   = e0 + 3 + p - l;
                    skip_at = p;
                end
                default: begin
                    push_vals(l, h, n, len);
                    ev_q.push_back('{K_DONE, e0 + len + 1});
                    b_end = e0 + len + 2;
                end
            endcase
        end

        start = 1'b1;
        next_cycle();
        start = 1'b0;

        if (mode == M_ABORT) begin
            while (cyc < e0 + p) next_cycle();
            abort = 1'b1;
            next_cycle();
            abort = 1'b0;
        end else if (mode == M_RESET) begin
            while (cyc < e0 + p) next_cycle();
            reset = 1'b0;
            next_cycle();
            reset       = 1'b1;
            rst_chk_cyc = cyc;
        end else if (mode == M_BUSYSTART) begin
            while (cyc < e0 + 2) next_cycle();
            lo       = 8'd9;
            hi       = 8'd3;
            n_sweeps = 4'd1;
            start    = 1'b1;
            next_cycle();
            start = 1'b0;
        end

        if (legal) begin
            while (cyc < b_end) next_cycle();
        end
        skip_at = -1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete within time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l, h, n, r, len;
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        lo       = '0;
        hi       = '0;
        n_sweeps = '0;
        repeat (3) next_cycle();
        reset       = 1'b1;
        rst_chk_cyc = cyc;
        mon_on      = 1'b1;
        next_cycle();

        run(2, 4, 1, M_NORM, 0);
        run(10, 12, 3, M_NORM, 0);
        run(0, 255, 1, M_NORM, 0);
        run(5, 5, 1, M_NORM, 0);
        run(9, 3, 1, M_NORM, 0);
        run(3, 9, 0, M_NORM, 0);
        run(5, 12, 2, M_SKIP, 7);
        run(4, 8, 2, M_NORM, 0);
        run(3, 7, 1, M_ABORT, 7);
        run(6, 9, 1, M_NORM, 0);
        run(20, 30, 2, M_RESET, 4);
        run(1, 5, 2, M_NORM, 0);
        run(1, 5, 1, M_STABRT, 0);
        run(7, 11, 2, M_BUSYSTART, 0);

        for (int it = 0; it < 30; it++) begin
            l   = int'($urandom_range(0, 240));
            h   = l + int'($urandom_range(1, 12));
            n   = int'($urandom_range(1, 5));
            len = 2 * n * (h - l) + 1;
            r   = int'($urandom_range(0, 9));
            case (r)
                4: run(l, h, n, M_ABORT, int'($urandom_range(1, len)));
                5: run(l, h, n, M_RESET, int'($urandom_range(1, len - 1)));
                6: run(l, h, n, M_SKIP, int'($urandom_range(l, h - 1)));
                7: begin
                    if ($urandom_range(0, 1) == 0) run(l, h, 0, M_NORM, 0);
                    else run(l, l - int'($urandom_range(0, l)), n, M_NORM, 0);
                end
                8: run(l, h, n, M_STABRT, 0);
                9: run(l, h, n, M_BUSYSTART, 0);
                default: run(l, h, n, M_NORM, 0);
            endcase
        end

        repeat (3) next_cycle();
        fin_cyc = cyc;
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
